// File: rtl/aes_pkg.sv
// Shared AES definitions used by the round-path blocks.
package aes_pkg;

    localparam int AES_BYTES = 16;

    typedef logic [AES_BYTES*8-1:0] state_t;
    typedef logic [7:0]             byte_t;

endpackage

// File: rtl/inverse_sub_bytes.sv
// Combinational AES inverse S-box for one byte.
module inverse_sub_bytes
    import aes_pkg::*;
(
    input  logic [7:0] sub_in,
    output logic [7:0] sub_out
);

    // Row r holds InvSbox(16r .. 16r+15). Entry 0 is the most significant
    // byte, so it sits at index 255 and the lookup uses ~sub_in.
    localparam logic [255:0][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign sub_out = INV_SBOX[~sub_in];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Applies InvSubBytes to a 128-bit state LANES bytes per cycle, in place,
// with valid/ready handshakes on both sides.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BYTES*8-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BYTES*8-1:0] out_state,
    output logic                   busy
);

    localparam int BEATS = AES_BYTES / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((LANES < 1) || ((AES_BYTES % LANES) != 0)) begin : g_lanes_check
        $error("inv_sub_bytes_seq: LANES must divide 16");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    fsm_e             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           work_q, work_d;

    int unsigned      base_idx;
    byte_t            lane_out [LANES];

    assign base_idx = 32'(cnt_q) * LANES;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        inverse_sub_bytes u_sbox (
            .sub_in  (work_q[(base_idx + gi)*8 +: 8]),
            .sub_out (lane_out[gi])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        in_ready = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d  = in_state;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < LANES; k++) begin
                    work_d[(base_idx + k)*8 +: 8] = lane_out[k];
                end
                if (cnt_q == CNT_W'(BEATS - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Reload is allowed in the same cycle the result leaves.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        work_d  = in_state;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    assign out_state = work_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/inv_sub_bytes_seq.md
# inv_sub_bytes_seq

Sequencer that applies the AES inverse S-box to a full 128-bit state using a reduced number of shared byte-substitution lanes. Accepts one state per valid/ready handshake, then substitutes LANES bytes per cycle in place until all 16 bytes are done. It presents the result on a valid/ready output. Sits in the decryption round path between inverse ShiftRows and AddRoundKey, trading latency for S-box area.

## Interface
- LANES, 4, inverse S-box instances used per cycle; legal values 1, 2, 4, 8, 16.
- BEATS, 16/LANES (derived, localparam), cycles needed to cover all 16 bytes.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_state is valid.
- in_ready  output  1  block can accept a state this cycle.
- in_state  input  128  state to substitute; byte i = in_state[8i+7:8i].
- out_valid  output  1  out_state holds a completed result.
- out_ready  input  1  consumer accepts out_state this cycle.
- out_state  output  128  substituted state; byte i = InvSbox(in byte i).
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, load in_state into work register, beat counter cnt=0, go to RUN.
- RUN: each cycle replace bytes cnt*LANES .. cnt*LANES+LANES-1 of the work register with their inverse S-box value. Increment cnt.
  - When cnt==BEATS-1, go to DONE.
  - cnt is $clog2(BEATS) bits (min 1), wraps to 0 on DONE entry.
- DONE: out_valid=1, out_state=work register.
  - out_ready=1: output handshake completes.
  - out_ready=0: hold DONE, out_state stable.
  - in_ready = out_ready in DONE. Simultaneous output and input handshake loads the new state and goes straight to RUN. Output handshake without input goes to IDLE.
- in_ready=0 in RUN. in_state is sampled only at an input handshake.
- Bytes are processed in ascending index order. A byte is substituted exactly once per block.
- Reset asserted (async, any state): FSM->IDLE, cnt=0, work register=0. Any in-flight block is discarded and no out_valid is produced for it.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, out_state=128'h0, busy=0.
- Latency: input handshake at edge E; out_valid rises after edge E+BEATS.
  - LANES=4: 4 cycles. LANES=1: 16 cycles. LANES=16: 1 cycle.
- Throughput with out_ready held high: one block per BEATS+1 cycles (RUN BEATS cycles + DONE 1 cycle, overlapped reload).
- All outputs registered or decoded from FSM state only. No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- in_ready in DONE depends combinationally on out_ready; that is the only input-to-output path.

## Structure
- Shared package aes_pkg: AES_BYTES=16, typedef state_t (logic [127:0]), typedef byte_t (logic [7:0]).
- Sub-module: LANES instances of the existing combinational inverse_sub_bytes (sub_in[7:0] -> sub_out[7:0]), lane k fed from work byte cnt*LANES+k via indexed part-select.
- FSM state enum local to this module.
- Elaboration-time check: LANES must divide 16.

## Test plan
- Reset: hold reset mid-RUN (after 2 beats) -> out_valid stays 0, in_ready=1, out_state=0 after release. Next block completes normally.
- Known vector, LANES=4: in_state bytes 0..15 = 00..0f -> out bytes 52 09 6a d5 30 36 a5 38 bf 40 a3 9e 81 f3 d7 fb; out_valid 4 cycles after accept.
- Edge values: all bytes 63 -> out all 00; all bytes ff -> all 7d; all bytes 52 -> all 48.
- Back-pressure: out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_state unchanged, in_ready=0. Release: single handshake, then IDLE.
- Back-to-back: in_valid and out_ready held high, 8 random states -> one result per 5 cycles (LANES=4), order preserved, each matches golden InvSbox model.
- Parameter sweep LANES=1, 2, 8, 16 with the 00..0f vector -> identical out_state; latency 16, 8, 2, 1 cycles respectively.
